// File: rtl/ensemble_axis_fanout_if.sv
// ensemble_axis_fanout_if
// Bundle of NUM_CH packed AXI-Stream channels sharing one handshake interface.
// Channel i of tdata occupies [i*DATA_WIDTH +: DATA_WIDTH], tkeep is packed
// the same way with KEEP_WIDTH, and tvalid/tready/tlast carry one bit per
// channel.
//   master modport: drives tdata, tkeep, tvalid, tlast; samples tready
//   slave modport : samples tdata, tkeep, tvalid, tlast; drives tready
interface ensemble_axis_fanout_if #(
   parameter int NUM_CH     = 3,
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = 4
);
   logic [NUM_CH*DATA_WIDTH-1:0] tdata;
   logic [NUM_CH*KEEP_WIDTH-1:0] tkeep;
   logic [NUM_CH-1:0]            tvalid;
   logic [NUM_CH-1:0]            tready;
   logic [NUM_CH-1:0]            tlast;

   modport master (
      output tdata, tkeep, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/ensemble_axis_fanout.sv
// ensemble_axis_fanout
// N-channel AXI-Stream buffer bank in front of the ensemble classifiers.
// Every channel owns a registered FIFO of DEPTH entries. In broadcast mode the
// channel 0 input is written into every FIFO at once so all classifiers see
// the same samples; outputs always drain independently.
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   cfg_broadcast   requested mode (1 = broadcast ch0, 0 = independent)
//   mode_broadcast  mode currently in effect
//   s_axis          packed per-channel input streams (slave side)
//   m_axis          packed per-channel output streams (master side)
//   occupancy       per-channel fill level 0..DEPTH, CNT_W bits each
module ensemble_axis_fanout #(
   parameter int NUM_CH     = 3,
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = 4,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_broadcast,
   output logic                      mode_broadcast,
   ensemble_axis_fanout_if.slave     s_axis,
   ensemble_axis_fanout_if.master    m_axis,
   output logic [NUM_CH*CNT_W-1:0]   occupancy
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = 1 + KEEP_WIDTH + DATA_WIDTH;

   logic [NUM_CH-1:0]  full;
   logic [NUM_CH-1:0]  m_valid;
   logic [NUM_CH-1:0]  push;
   logic [NUM_CH-1:0]  pop;
   logic [NUM_CH-1:0]  in_pkt;
   logic [CNT_W-1:0]   cnt  [NUM_CH];
   logic [ENTRY_W-1:0] head [NUM_CH];

   // Full and valid come straight from the registered counts, so ready never
   // depends combinationally on the downstream tready.
   always_comb begin
      full    = '0;
      m_valid = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         full[i]    = (cnt[i] == CNT_W'(DEPTH));
         m_valid[i] = (cnt[i] != '0);
      end
   end

   // Input acceptance. In broadcast mode only channel 0 is ever ready, and
   // only when every FIFO has room, because one beat lands in all of them.
   always_comb begin
      s_axis.tready = '0;
      push          = '0;
      if (!rst) begin
         if (mode_broadcast) begin
            s_axis.tready[0] = ~|full;
            push             = {NUM_CH{s_axis.tvalid[0] & ~|full}};
         end else begin
            s_axis.tready = ~full;
            push          = s_axis.tvalid & ~full;
         end
      end
   end

   assign pop = m_valid & m_axis.tready;

   // One FIFO per channel. Memory is cleared on reset so no stale beat can
   // ever appear on the outputs after a reset mid-packet.
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [ENTRY_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]   wr_ptr;
      logic [PTR_W-1:0]   rd_ptr;
      logic [CNT_W-1:0]   count;
      logic [ENTRY_W-1:0] wr_entry;

      assign wr_entry = mode_broadcast
         ? {s_axis.tlast[0], s_axis.tkeep[0 +: KEEP_WIDTH],
            s_axis.tdata[0 +: DATA_WIDTH]}
         : {s_axis.tlast[ch], s_axis.tkeep[ch*KEEP_WIDTH +: KEEP_WIDTH],
            s_axis.tdata[ch*DATA_WIDTH +: DATA_WIDTH]};

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
               mem[e] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[ch]) begin
               mem[wr_ptr] <= wr_entry;
               wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop[ch]) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push[ch], pop[ch]})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end

      assign cnt[ch]  = count;
      assign head[ch] = mem[rd_ptr];
   end

   // Unpack the head entries onto the packed output buses.
   always_comb begin
      m_axis.tdata  = '0;
      m_axis.tkeep  = '0;
      m_axis.tlast  = '0;
      m_axis.tvalid = m_valid;
      occupancy     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH] = head[i][DATA_WIDTH-1:0];
         m_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = head[i][DATA_WIDTH +: KEEP_WIDTH];
         m_axis.tlast[i]                          = head[i][ENTRY_W-1];
         occupancy[i*CNT_W +: CNT_W]              = cnt[i];
      end
   end

   // Packet tracking. In broadcast mode the other channels' inputs are
   // ignored, so only channel 0 can open or close a packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_pkt <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i] && (!mode_broadcast || i == 0)) begin
               in_pkt[i] <= ~s_axis.tlast[i];
            end
         end
      end
   end

   // The mode only follows the request on a quiet cycle between packets, so
   // a switch can never split a packet across two modes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_broadcast <= 1'b0;
      end else if (!(|in_pkt) && !(|push)) begin
         mode_broadcast <= cfg_broadcast;
      end
   end

endmodule

// File: tb/tb_ensemble_axis_fanout.sv
// tb_ensemble_axis_fanout
// Directed self-checking bench for ensemble_axis_fanout with NUM_CH=3,
// DATA_WIDTH=32, KEEP_WIDTH=4, DEPTH=4. Inputs change 1ns after the rising
// edge and outputs are checked at that same point, well away from the edge.
module tb_ensemble_axis_fanout;

   localparam int NUM_CH     = 3;
   localparam int DATA_WIDTH = 32;
   localparam int KEEP_WIDTH = 4;
   localparam int DEPTH      = 4;
   localparam int CNT_W      = 3;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    cfg_broadcast = 1'b0;
   logic                    mode_broadcast;
   logic [NUM_CH*CNT_W-1:0] occupancy;

   int checks = 0;
   int errors = 0;

   logic [31:0] rx0[$];
   logic [31:0] rx1[$];
   logic [31:0] rx2[$];

   ensemble_axis_fanout_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) s_if();
   ensemble_axis_fanout_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) m_if();

   ensemble_axis_fanout #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH),
      .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cfg_broadcast(cfg_broadcast),
      .mode_broadcast(mode_broadcast),
      .s_axis(s_if),
      .m_axis(m_if),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // Record every beat that leaves on each output, sampled mid-cycle.
   always @(negedge clk) begin
      if (m_if.tvalid[0] && m_if.tready[0]) rx0.push_back(m_if.tdata[0 +: 32]);
      if (m_if.tvalid[1] && m_if.tready[1]) rx1.push_back(m_if.tdata[32 +: 32]);
      if (m_if.tvalid[2] && m_if.tready[2]) rx2.push_back(m_if.tdata[64 +: 32]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dat(input int ch);
      return m_if.tdata[ch*32 +: 32];
   endfunction

   function automatic logic [CNT_W-1:0] occ(input int ch);
      return occupancy[ch*CNT_W +: CNT_W];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (m_if.tvalid !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_tvalid got %b want %b", m_if.tvalid, 3'b000);
      end
      checks++;
      if (s_if.tready !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_s_tready got %b want %b", s_if.tready, 3'b000);
      end
      checks++;
      if (occupancy !== 9'd0) begin
         errors++;
         $display("[TB] FAIL reset_occupancy got %h want 0", occupancy);
      end
      checks++;
      if (mode_broadcast !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mode got %b want 0", mode_broadcast);
      end
      checks++;
      if (m_if.tdata !== 96'd0 || m_if.tkeep !== 12'd0 || m_if.tlast !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_outputs got %h/%h/%b want 0", m_if.tdata, m_if.tkeep, m_if.tlast);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (s_if.tready !== 3'b111) begin
         errors++;
         $display("[TB] FAIL release_s_tready got %b want %b", s_if.tready, 3'b111);
      end
   endtask

   task automatic test_independent();
      logic [31:0] exp_data [3];
      exp_data = '{32'hA0, 32'hA1, 32'hA2};
      m_if.tready = 3'b010;
      checks++;
      if (m_if.tvalid !== 3'b000) begin
         errors++;
         $display("[TB] FAIL indep_pre_tvalid got %b want %b", m_if.tvalid, 3'b000);
      end
      for (int k = 0; k < 3; k++) begin
         s_if.tvalid              = 3'b010;
         s_if.tdata[32 +: 32]     = exp_data[k];
         s_if.tkeep[4 +: 4]       = 4'hF;
         s_if.tlast               = (k == 2) ? 3'b010 : 3'b000;
         tick();
         checks++;
         if (m_if.tvalid !== 3'b010 || dat(1) !== exp_data[k] || m_if.tlast[1] !== (k == 2)) begin
            errors++;
            $display("[TB] FAIL indep_beat%0d got v=%b d=%h l=%b want v=010 d=%h l=%b",
                     k, m_if.tvalid, dat(1), m_if.tlast[1], exp_data[k], (k == 2));
         end
      end
      s_if.tvalid = 3'b000;
      s_if.tlast  = 3'b000;
      tick();
      checks++;
      if (m_if.tvalid !== 3'b000) begin
         errors++;
         $display("[TB] FAIL indep_drained got %b want %b", m_if.tvalid, 3'b000);
      end
   endtask

   task automatic test_fill();
      logic [31:0] fill_data [5];
      logic [3:0]  fill_keep [5];
      logic        exp_rdy;
      logic [CNT_W-1:0] exp_occ;
      fill_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
      fill_keep = '{4'hF, 4'h3, 4'hF, 4'h1, 4'hF};
      m_if.tready = 3'b000;
      for (int k = 0; k < 5; k++) begin
         s_if.tvalid          = 3'b100;
         s_if.tdata[64 +: 32] = fill_data[k];
         s_if.tkeep[8 +: 4]   = fill_keep[k];
         s_if.tlast           = (k == 3) ? 3'b100 : 3'b000;
         exp_rdy = (k < 4);
         checks++;
         if (s_if.tready[2] !== exp_rdy) begin
            errors++;
            $display("[TB] FAIL fill_ready%0d got %b want %b", k, s_if.tready[2], exp_rdy);
         end
         tick();
         exp_occ = (k < 4) ? CNT_W'(k + 1) : CNT_W'(4);
         checks++;
         if (occ(2) !== exp_occ) begin
            errors++;
            $display("[TB] FAIL fill_occ%0d got %0d want %0d", k, occ(2), exp_occ);
         end
      end
      s_if.tvalid = 3'b000;
      s_if.tlast  = 3'b000;
      m_if.tready = 3'b100;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (m_if.tvalid[2] !== 1'b1 || dat(2) !== fill_data[k] || m_if.tkeep[8 +: 4] !== fill_keep[k]) begin
            errors++;
            $display("[TB] FAIL drain_beat%0d got v=%b d=%h k=%h want v=1 d=%h k=%h",
                     k, m_if.tvalid[2], dat(2), m_if.tkeep[8 +: 4], fill_data[k], fill_keep[k]);
         end
         tick();
      end
      checks++;
      if (occ(2) !== 3'd0 || m_if.tvalid !== 3'b000) begin
         errors++;
         $display("[TB] FAIL drain_empty got occ=%0d v=%b want occ=0 v=000", occ(2), m_if.tvalid);
      end
   endtask

   task automatic test_broadcast();
      logic [31:0] bc_data [2];
      bc_data = '{32'h11, 32'h22};
      cfg_broadcast = 1'b1;
      m_if.tready   = 3'b111;
      tick();
      checks++;
      if (mode_broadcast !== 1'b1 || s_if.tready !== 3'b001) begin
         errors++;
         $display("[TB] FAIL bcast_enter got mode=%b rdy=%b want mode=1 rdy=001", mode_broadcast, s_if.tready);
      end
      for (int k = 0; k < 2; k++) begin
         s_if.tvalid = 3'b111;
         s_if.tdata  = {32'hDEAD_0002, 32'hDEAD_0001, bc_data[k]};
         s_if.tkeep  = 12'hFFF;
         s_if.tlast  = (k == 1) ? 3'b001 : 3'b000;
         tick();
         for (int ch = 0; ch < 3; ch++) begin
            checks++;
            if (m_if.tvalid[ch] !== 1'b1 || dat(ch) !== bc_data[k] || m_if.tlast[ch] !== (k == 1)) begin
               errors++;
               $display("[TB] FAIL bcast_ch%0d_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        ch, k, m_if.tvalid[ch], dat(ch), m_if.tlast[ch], bc_data[k], (k == 1));
            end
         end
      end
      s_if.tvalid = 3'b000;
      s_if.tlast  = 3'b000;
      tick();
      checks++;
      if (m_if.tvalid !== 3'b000 || occupancy !== 9'd0) begin
         errors++;
         $display("[TB] FAIL bcast_drained got v=%b occ=%h want v=000 occ=0", m_if.tvalid, occupancy);
      end
   endtask

   task automatic test_broadcast_backpressure();
      logic [31:0] bp_data [6];
      int w;
      bp_data = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
      rx0.delete();
      rx1.delete();
      rx2.delete();
      m_if.tready = 3'b101;
      for (int k = 0; k < 4; k++) begin
         s_if.tvalid        = 3'b001;
         s_if.tdata[0 +: 32] = bp_data[k];
         s_if.tlast         = 3'b000;
         tick();
      end
      s_if.tdata[0 +: 32] = bp_data[4];
      checks++;
      if (s_if.tready !== 3'b000 || occ(1) !== 3'd4) begin
         errors++;
         $display("[TB] FAIL bp_full got rdy=%b occ1=%0d want rdy=000 occ1=4", s_if.tready, occ(1));
      end
      tick();
      tick();
      checks++;
      if (s_if.tready !== 3'b000 || occ(1) !== 3'd4) begin
         errors++;
         $display("[TB] FAIL bp_hold got rdy=%b occ1=%0d want rdy=000 occ1=4", s_if.tready, occ(1));
      end
      m_if.tready = 3'b111;
      for (int k = 4; k < 6; k++) begin
         s_if.tvalid         = 3'b001;
         s_if.tdata[0 +: 32] = bp_data[k];
         s_if.tlast          = (k == 5) ? 3'b001 : 3'b000;
         w = 0;
         while (s_if.tready[0] !== 1'b1 && w < 20) begin
            tick();
            w++;
         end
         if (w >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL bp_ready_timeout got rdy=%b want 1", s_if.tready[0]);
         end
         tick();
      end
      s_if.tvalid = 3'b000;
      s_if.tlast  = 3'b000;
      repeat (8) tick();
      checks++;
      if (rx0.size() != 6 || rx1.size() != 6 || rx2.size() != 6) begin
         errors++;
         $display("[TB] FAIL bp_counts got %0d/%0d/%0d want 6/6/6", rx0.size(), rx1.size(), rx2.size());
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= rx1.size() || rx1[i] !== bp_data[i]) begin
            errors++;
            $display("[TB] FAIL bp_ch1_beat%0d got %h want %h", i, (i < rx1.size()) ? rx1[i] : 32'hX, bp_data[i]);
         end
         checks++;
         if (i >= rx0.size() || i >= rx2.size() || rx0[i] !== bp_data[i] || rx2[i] !== bp_data[i]) begin
            errors++;
            $display("[TB] FAIL bp_ch02_beat%0d got %h/%h want %h", i,
                     (i < rx0.size()) ? rx0[i] : 32'hX, (i < rx2.size()) ? rx2[i] : 32'hX, bp_data[i]);
         end
      end
   endtask

   task automatic test_mode_switch();
      m_if.tready = 3'b111;
      s_if.tvalid = 3'b001;
      s_if.tdata[0 +: 32] = 32'hD0;
      s_if.tlast  = 3'b000;
      tick();
      cfg_broadcast = 1'b0;
      s_if.tdata[0 +: 32] = 32'hD1;
      tick();
      checks++;
      if (mode_broadcast !== 1'b1) begin
         errors++;
         $display("[TB] FAIL switch_mid1 got %b want 1", mode_broadcast);
      end
      s_if.tvalid = 3'b000;
      tick();
      checks++;
      if (mode_broadcast !== 1'b1) begin
         errors++;
         $display("[TB] FAIL switch_gap got %b want 1", mode_broadcast);
      end
      s_if.tvalid = 3'b001;
      s_if.tdata[0 +: 32] = 32'hD2;
      s_if.tlast  = 3'b001;
      tick();
      checks++;
      if (mode_broadcast !== 1'b1) begin
         errors++;
         $display("[TB] FAIL switch_last got %b want 1", mode_broadcast);
      end
      s_if.tvalid = 3'b000;
      s_if.tlast  = 3'b000;
      tick();
      checks++;
      if (mode_broadcast !== 1'b0 || s_if.tready !== 3'b111) begin
         errors++;
         $display("[TB] FAIL switch_done got mode=%b rdy=%b want mode=0 rdy=111", mode_broadcast, s_if.tready);
      end
   endtask

   task automatic test_async_reset();
      m_if.tready = 3'b000;
      s_if.tvalid = 3'b111;
      s_if.tdata  = {32'hE2, 32'hE1, 32'hE0};
      s_if.tkeep  = 12'hFFF;
      s_if.tlast  = 3'b000;
      tick();
      tick();
      s_if.tvalid = 3'b000;
      checks++;
      if (occupancy !== {3'd2, 3'd2, 3'd2}) begin
         errors++;
         $display("[TB] FAIL half_full got %h want %h", occupancy, {3'd2, 3'd2, 3'd2});
      end
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (m_if.tvalid !== 3'b000 || s_if.tready !== 3'b000 || occupancy !== 9'd0 || m_if.tdata !== 96'd0) begin
         errors++;
         $display("[TB] FAIL async_reset got v=%b rdy=%b occ=%h d=%h want all 0",
                  m_if.tvalid, s_if.tready, occupancy, m_if.tdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      checks++;
      if (s_if.tready !== 3'b111 || occupancy !== 9'd0 || m_if.tvalid !== 3'b000 || mode_broadcast !== 1'b0) begin
         errors++;
         $display("[TB] FAIL after_reset got rdy=%b occ=%h v=%b mode=%b want rdy=111 occ=0 v=000 mode=0",
                  s_if.tready, occupancy, m_if.tvalid, mode_broadcast);
      end
      cfg_broadcast = 1'b1;
      tick();
      checks++;
      if (mode_broadcast !== 1'b1) begin
         errors++;
         $display("[TB] FAIL in_pkt_cleared got mode=%b want 1", mode_broadcast);
      end
      cfg_broadcast = 1'b0;
      tick();
   endtask

   initial begin
      s_if.tvalid = '0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = '0;
      m_if.tready = '0;
      test_reset();
      test_independent();
      test_fill();
      test_broadcast();
      test_broadcast_backpressure();
      test_mode_switch();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
